// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-port BRAM arbiter.
package bram_arb_pkg;

  localparam int unsigned NUM_PORTS      = 2;
  localparam int unsigned ARB_DATA_WIDTH = 32;
  localparam int unsigned ARB_ADDR_WIDTH = 15;

  typedef struct packed {
    logic [ARB_DATA_WIDTH/8-1:0] we;
    logic [ARB_ADDR_WIDTH-1:0]   addr;
    logic [ARB_DATA_WIDTH-1:0]   wdata;
  } bram_req_t;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/bram_rd_tracker.sv
// Delays an accepted-read tag by READ_LATENCY cycles and turns it into a
// per-port read-valid strobe aligned with bram_dout.
module bram_rd_tracker
  import bram_arb_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 push_owner,
  output logic [NUM_PORTS-1:0] rvalid
);

  rd_tag_t pipe [READ_LATENCY];
  rd_tag_t tail;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= '{valid: push, owner: push_owner};
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tail = pipe[READ_LATENCY-1];

  always_comb begin
    rvalid = '0;
    if (rst && tail.valid) begin
      rvalid[tail.owner] = 1'b1;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-port arbiter in front of a single-port BRAM: round-robin with bounded
// bursts, combinational grant, and read-data return to the issuing port.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_BURST    = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PORTS-1:0]                   req_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] we_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]                   gnt_o,
  output logic [NUM_PORTS-1:0]                   rvalid_o,
  output logic [DATA_WIDTH-1:0]                  rdata_o,
  output logic                                   bram_en,
  output logic [DATA_WIDTH/8-1:0]                bram_we,
  output logic [ADDR_WIDTH-1:0]                  bram_addr,
  output logic [DATA_WIDTH-1:0]                  bram_din,
  input  logic [DATA_WIDTH-1:0]                  bram_dout,
  output logic                                   bram_reset
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] BURST_ONE = CW'(1);

  logic          last_grant;
  logic [CW-1:0] burst_cnt;
  logic          burst_open;
  logic          winner;
  logic          rr_switch;
  logic          accept;
  logic          is_read;

  // A contended port only keeps the grant if it was already streaming
  // (solo or extended) when the other port showed up; once a round-robin
  // hand-over has happened the ports alternate strictly.
  always_comb begin
    winner    = 1'b0;
    rr_switch = 1'b0;
    unique case (req_i)
      2'b01: winner = 1'b0;
      2'b10: winner = 1'b1;
      2'b11: begin
        if (burst_open && (burst_cnt < BURST_MAX)) begin
          winner = last_grant;
        end else begin
          winner    = ~last_grant;
          rr_switch = 1'b1;
        end
      end
      default: winner = 1'b0;
    endcase

    accept = rst && (|req_i);
    gnt_o  = '0;
    if (accept) begin
      gnt_o[winner] = 1'b1;
    end
    is_read = accept && (we_i[winner] == '0);
  end

  always_comb begin
    bram_en   = accept;
    bram_we   = accept ? we_i[winner] : '0;
    bram_addr = addr_i[winner];
    bram_din  = wdata_i[winner];
  end

  assign bram_reset = ~rst;
  assign rdata_o    = bram_dout;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= 1'b1;
      burst_cnt  <= '0;
      burst_open <= 1'b0;
    end else if (accept) begin
      last_grant <= winner;
      burst_open <= ~rr_switch;
      if (winner == last_grant) begin
        if (burst_cnt != BURST_MAX) begin
          burst_cnt <= burst_cnt + BURST_ONE;
        end
      end else begin
        burst_cnt <= BURST_ONE;
      end
    end
  end

  bram_rd_tracker #(
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_tracker (
    .clk        (clk),
    .rst        (rst),
    .push       (is_read),
    .push_owner (winner),
    .rvalid     (rvalid_o)
  );

endmodule
